// File: rtl/pe_pkg.sv
// Shared constants and helpers for the systolic processing element.
package pe_pkg;

  localparam logic PE_MODE_WS = 1'b0;
  localparam logic PE_MODE_LA = 1'b1;

  // Width of a partial sum: full signed product plus growth headroom for the column.
  function automatic int psum_width(input int data_w, input int guard_w);
    return 2 * data_w + guard_w;
  endfunction

endpackage

// File: rtl/pe_sat_add.sv
// Signed partial-sum adder that either clamps or wraps on overflow.
module pe_sat_add #(
  parameter int PSUM_W = 20,
  parameter int SAT_EN = 1
) (
  input  logic signed [PSUM_W-1:0] i_a,
  input  logic signed [PSUM_W-1:0] i_b,
  output logic signed [PSUM_W-1:0] o_sum,
  output logic                     o_ovf
);

  localparam logic signed [PSUM_W-1:0] MAX_VAL = {1'b0, {(PSUM_W-1){1'b1}}};
  localparam logic signed [PSUM_W-1:0] MIN_VAL = {1'b1, {(PSUM_W-1){1'b0}}};

  logic signed [PSUM_W:0] w_full;

  assign w_full = {i_a[PSUM_W-1], i_a} + {i_b[PSUM_W-1], i_b};
  assign o_ovf  = w_full[PSUM_W] ^ w_full[PSUM_W-1];

  // Clamp toward the sign of the true sum when saturation is enabled, otherwise wrap.
  always_comb begin
    o_sum = w_full[PSUM_W-1:0];
    if ((SAT_EN != 0) && o_ovf) begin
      o_sum = w_full[PSUM_W] ? MIN_VAL : MAX_VAL;
    end
  end

endmodule

// File: rtl/pe_dbuf_mac.sv
// Systolic PE with double-buffered weights, WS psum chaining and LA accumulate/drain.
module pe_dbuf_mac
  import pe_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int GUARD_W  = 4,
  parameter int PIPE_MUL = 0,
  parameter int SAT_EN   = 1,
  localparam int PSUM_W  = psum_width(DATA_W, GUARD_W)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic                     w_load,
  input  logic signed [DATA_W-1:0] w_in,
  output logic signed [DATA_W-1:0] w_out,
  input  logic                     w_swap,
  input  logic                     x_valid_in,
  input  logic signed [DATA_W-1:0] x_in,
  output logic                     x_valid_out,
  output logic signed [DATA_W-1:0] x_out,
  input  logic signed [PSUM_W-1:0] psum_in,
  output logic                     psum_valid_out,
  output logic signed [PSUM_W-1:0] psum_out,
  input  logic                     acc_drain,
  output logic                     ovf
);

  logic signed [DATA_W-1:0]   r_shadow_w;
  logic signed [DATA_W-1:0]   r_active_w;
  logic signed [DATA_W-1:0]   r_w_out;
  logic signed [DATA_W-1:0]   r_x_out;
  logic                       r_x_valid_out;
  logic signed [PSUM_W-1:0]   r_psum_out;
  logic                       r_psum_valid_out;
  logic signed [PSUM_W-1:0]   r_acc;
  logic                       r_ovf;

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [PSUM_W-1:0]   w_prod_ext;

  // WS operands as seen by the output stage (either live or one cycle delayed).
  logic                       w_st_ws;
  logic                       w_st_valid;
  logic signed [PSUM_W-1:0]   w_st_prod;
  logic signed [PSUM_W-1:0]   w_st_psum;

  logic                       w_drain;
  logic                       w_la_add;
  logic                       w_add_used;
  logic signed [PSUM_W-1:0]   w_add_a;
  logic signed [PSUM_W-1:0]   w_add_b;
  logic signed [PSUM_W-1:0]   w_sum;
  logic                       w_add_ovf;

  assign w_prod     = x_in * r_active_w;
  assign w_prod_ext = {{(PSUM_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};

  // Shadow/active weight pair; a swap always takes the shadow value from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shadow_w <= '0;
      r_active_w <= '0;
      r_w_out    <= '0;
    end else begin
      if (w_load) begin
        r_shadow_w <= w_in;
        r_w_out    <= w_in;
      end
      if (w_swap) begin
        r_active_w <= r_shadow_w;
      end
    end
  end

  // Activation forwarding to the east neighbour, one cycle regardless of mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x_out       <= '0;
      r_x_valid_out <= 1'b0;
    end else begin
      r_x_out       <= x_in;
      r_x_valid_out <= x_valid_in;
    end
  end

  generate
    if (PIPE_MUL != 0) begin : g_pipe
      logic                     r_p_ws;
      logic                     r_p_valid;
      logic signed [PSUM_W-1:0] r_p_prod;
      logic signed [PSUM_W-1:0] r_p_psum;

      // Product register with psum_in delayed alongside so the WS add stays aligned.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_p_ws    <= 1'b0;
          r_p_valid <= 1'b0;
          r_p_prod  <= '0;
          r_p_psum  <= '0;
        end else begin
          r_p_ws    <= (mode == PE_MODE_WS);
          r_p_valid <= x_valid_in && (mode == PE_MODE_WS);
          r_p_prod  <= w_prod_ext;
          r_p_psum  <= psum_in;
        end
      end

      assign w_st_ws    = r_p_ws;
      assign w_st_valid = r_p_valid;
      assign w_st_prod  = r_p_prod;
      assign w_st_psum  = r_p_psum;
    end else begin : g_nopipe
      assign w_st_ws    = (mode == PE_MODE_WS);
      assign w_st_valid = x_valid_in && (mode == PE_MODE_WS);
      assign w_st_prod  = w_prod_ext;
      assign w_st_psum  = psum_in;
    end
  endgenerate

  // An in-flight WS entry owns psum_out and the adder; LA work yields to it.
  assign w_drain    = (mode == PE_MODE_LA) && acc_drain && !w_st_ws;
  assign w_la_add   = (mode == PE_MODE_LA) && x_valid_in && !w_st_valid && !w_drain;
  assign w_add_used = w_st_valid || w_la_add;
  assign w_add_a    = w_st_valid ? w_st_psum : r_acc;
  assign w_add_b    = w_st_valid ? w_st_prod : w_prod_ext;

  pe_sat_add #(
    .PSUM_W (PSUM_W),
    .SAT_EN (SAT_EN)
  ) u_sat_add (
    .i_a   (w_add_a),
    .i_b   (w_add_b),
    .o_sum (w_sum),
    .o_ovf (w_add_ovf)
  );

  // South output: WS result or pass-through, otherwise a one-cycle LA drain pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_psum_out       <= '0;
      r_psum_valid_out <= 1'b0;
    end else if (w_st_ws) begin
      r_psum_out       <= w_st_valid ? w_sum : w_st_psum;
      r_psum_valid_out <= w_st_valid;
    end else if (w_drain) begin
      r_psum_out       <= r_acc;
      r_psum_valid_out <= 1'b1;
    end else begin
      r_psum_valid_out <= 1'b0;
    end
  end

  // Local accumulator restarts on drain (seeded with the current product) and the overflow flag is sticky.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_drain) begin
        r_acc <= x_valid_in ? w_prod_ext : '0;
      end else if (w_la_add) begin
        r_acc <= w_sum;
      end
      if (w_add_used && w_add_ovf) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign w_out          = r_w_out;
  assign x_out          = r_x_out;
  assign x_valid_out    = r_x_valid_out;
  assign psum_out       = r_psum_out;
  assign psum_valid_out = r_psum_valid_out;
  assign ovf            = r_ovf;

endmodule

// File: tb/tb_pe_dbuf_mac.sv
// Self-checking bench: three PE variants driven in parallel against an arithmetic reference model.
module tb_pe_dbuf_mac;

  localparam int     DATA_W = 8;
  localparam int     GUARD_W = 4;
  localparam int     PSUM_W = 2 * DATA_W + GUARD_W;
  localparam longint PMAX = (longint'(1) << (PSUM_W - 1)) - 1;
  localparam longint PMIN = -(longint'(1) << (PSUM_W - 1));
  localparam longint PRANGE = longint'(1) << PSUM_W;

  logic clk;
  logic rstN;
  logic mode;
  logic wLoad;
  logic signed [DATA_W-1:0] wIn;
  logic wSwap;
  logic xValidIn;
  logic signed [DATA_W-1:0] xIn;
  logic signed [PSUM_W-1:0] psumIn;
  logic accDrain;

  logic signed [DATA_W-1:0] wOut [3];
  logic signed [DATA_W-1:0] xOut [3];
  logic                     xValidOut [3];
  logic signed [PSUM_W-1:0] psumOut [3];
  logic                     psumValidOut [3];
  logic                     ovf [3];

  int errors = 0;
  int checks = 0;

  // Reference state: weights are shared, everything downstream is per variant.
  int     mShadow, mActive, mWOut, mXOut;
  bit     mXValid;
  longint mAcc [3];
  longint mPsum [3];
  bit     mValid [3];
  bit     mOvf [3];
  bit     pendWs [3];
  bit     pendValid [3];
  bit     pendOf [3];
  longint pendVal [3];

  // Variant 0: combinational product, saturating. Variant 1: registered product. Variant 2: wrapping.
  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      pe_dbuf_mac #(
        .DATA_W   (DATA_W),
        .GUARD_W  (GUARD_W),
        .PIPE_MUL (g == 1 ? 1 : 0),
        .SAT_EN   (g == 2 ? 0 : 1)
      ) dut (
        .clk            (clk),
        .rst_n          (rstN),
        .mode           (mode),
        .w_load         (wLoad),
        .w_in           (wIn),
        .w_out          (wOut[g]),
        .w_swap         (wSwap),
        .x_valid_in     (xValidIn),
        .x_in           (xIn),
        .x_valid_out    (xValidOut[g]),
        .x_out          (xOut[g]),
        .psum_in        (psumIn),
        .psum_valid_out (psumValidOut[g]),
        .psum_out       (psumOut[g]),
        .acc_drain      (accDrain),
        .ovf            (ovf[g])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit cfgPipe(input int k);
    return k == 1;
  endfunction

  function automatic bit cfgSat(input int k);
    return k != 2;
  endfunction

  // Saturate or wrap an exact integer sum into the psum range, reporting whether it was out of range.
  function automatic longint satf(input longint s, input bit satEn, output bit outOfRange);
    longint w;
    outOfRange = (s > PMAX) || (s < PMIN);
    if (!outOfRange) return s;
    if (satEn) return (s > PMAX) ? PMAX : PMIN;
    w = s % PRANGE;
    if (w < 0) w += PRANGE;
    if (w > PMAX) w -= PRANGE;
    return w;
  endfunction

  // Advance the reference model by one clock using the inputs presented before the edge.
  task automatic modelStep();
    longint prod, nVal, eVal;
    bit nWs, nValid, nOf, eWs, eValid, eOf, drainTaken, aOf;
    if (!rstN) begin
      mShadow = 0; mActive = 0; mWOut = 0; mXOut = 0; mXValid = 0;
      for (int k = 0; k < 3; k++) begin
        mAcc[k] = 0; mPsum[k] = 0; mValid[k] = 0; mOvf[k] = 0;
        pendWs[k] = 0; pendValid[k] = 0; pendOf[k] = 0; pendVal[k] = 0;
      end
      return;
    end
    prod = longint'(xIn) * longint'(mActive);
    for (int k = 0; k < 3; k++) begin
      nWs = (mode == 1'b0);
      nValid = nWs && xValidIn;
      nOf = 0;
      if (nValid) nVal = satf(longint'(psumIn) + prod, cfgSat(k), nOf);
      else nVal = longint'(psumIn);
      if (cfgPipe(k)) begin
        eWs = pendWs[k]; eValid = pendValid[k]; eOf = pendOf[k]; eVal = pendVal[k];
        pendWs[k] = nWs; pendValid[k] = nValid; pendOf[k] = nOf; pendVal[k] = nVal;
      end else begin
        eWs = nWs; eValid = nValid; eOf = nOf; eVal = nVal;
      end
      drainTaken = (mode == 1'b1) && accDrain && !eWs;
      if (eWs) begin
        mPsum[k] = eVal;
        mValid[k] = eValid;
        if (eValid && eOf) mOvf[k] = 1;
      end else if (drainTaken) begin
        mPsum[k] = mAcc[k];
        mValid[k] = 1;
      end else begin
        mValid[k] = 0;
      end
      if (drainTaken) begin
        mAcc[k] = xValidIn ? prod : 0;
      end else if ((mode == 1'b1) && xValidIn && !eValid) begin
        mAcc[k] = satf(mAcc[k] + prod, cfgSat(k), aOf);
        if (aOf) mOvf[k] = 1;
      end
    end
    if (wSwap) mActive = mShadow;
    if (wLoad) begin
      mShadow = int'(wIn);
      mWOut = int'(wIn);
    end
    mXOut = int'(xIn);
    mXValid = xValidIn;
  endtask

  task automatic checkVal(input string tag, input int k,
                          input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  // Clock the inputs in, then sample outputs 1 time unit after the edge and update the model.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    modelStep();
  endtask

  task automatic checkOutput();
    for (int k = 0; k < 3; k++) begin
      checkVal("psum_out", k, psumOut[k], mPsum[k]);
      checkVal("psum_valid_out", k, psumValidOut[k], mValid[k]);
      checkVal("ovf", k, ovf[k], mOvf[k]);
      checkVal("x_out", k, xOut[k], mXOut);
      checkVal("x_valid_out", k, xValidOut[k], mXValid);
      checkVal("w_out", k, wOut[k], mWOut);
    end
  endtask

  task automatic setIdle();
    wLoad = 0; wIn = '0; wSwap = 0; xValidIn = 0; xIn = '0; psumIn = '0; accDrain = 0;
  endtask

  task automatic stepIdle(input int n);
    for (int i = 0; i < n; i++) begin
      setIdle();
      applyStimulus();
      checkOutput();
    end
  endtask

  int phasePos;
  bit quiet;

  initial begin
    rstN = 0; mode = 0;
    setIdle();
    modelStep();

    $display("[TB] reset with garbage inputs");
    for (int i = 0; i < 3; i++) begin
      rstN = 0; mode = 1'($urandom); wLoad = 1; wIn = DATA_W'($urandom); wSwap = 1;
      xValidIn = 1; xIn = DATA_W'($urandom); psumIn = PSUM_W'($urandom); accDrain = 1;
      applyStimulus();
      checkOutput();
      for (int k = 0; k < 3; k++) begin
        checkVal("rst_psum_out", k, psumOut[k], 0);
        checkVal("rst_ovf", k, ovf[k], 0);
        checkVal("rst_x_out", k, xOut[k], 0);
      end
    end
    rstN = 1; mode = 0;
    setIdle();
    applyStimulus();
    checkOutput();
    checkVal("post_rst_psum_out", 0, psumOut[0], 0);
    checkVal("post_rst_w_out", 0, wOut[0], 0);

    $display("[TB] double-buffered weights");
    setIdle(); wLoad = 1; wIn = 3; applyStimulus(); checkOutput();
    checkVal("db_w_out", 0, wOut[0], 3);
    setIdle(); wSwap = 1; applyStimulus(); checkOutput();
    setIdle(); wLoad = 1; wIn = -2; applyStimulus(); checkOutput();
    setIdle(); xValidIn = 1; xIn = 5; psumIn = 10; applyStimulus(); checkOutput();
    checkVal("db_shadow_only", 0, psumOut[0], 25);
    checkVal("db_shadow_only_valid", 0, psumValidOut[0], 1);
    setIdle(); wSwap = 1; applyStimulus(); checkOutput();
    setIdle(); xValidIn = 1; xIn = 5; psumIn = 10; applyStimulus(); checkOutput();
    checkVal("db_after_swap", 0, psumOut[0], 0);
    setIdle(); wLoad = 1; wIn = 9; wSwap = 1; applyStimulus(); checkOutput();
    setIdle(); xValidIn = 1; xIn = 5; applyStimulus(); checkOutput();
    checkVal("db_load_swap_old", 0, psumOut[0], -10);
    setIdle(); wSwap = 1; applyStimulus(); checkOutput();
    setIdle(); xValidIn = 1; xIn = 5; applyStimulus(); checkOutput();
    checkVal("db_load_swap_new", 0, psumOut[0], 45);

    $display("[TB] WS latency and pass-through");
    stepIdle(2);
    setIdle(); xValidIn = 1; xIn = 3; psumIn = 7; applyStimulus(); checkOutput();
    checkVal("lat_p0_valid", 0, psumValidOut[0], 1);
    checkVal("lat_p1_valid_early", 1, psumValidOut[1], 0);
    checkVal("lat_p0_sum", 0, psumOut[0], 34);
    setIdle(); psumIn = 100; xIn = 8'sh5A; applyStimulus(); checkOutput();
    checkVal("lat_p0_passthru", 0, psumOut[0], 100);
    checkVal("lat_p0_valid_drop", 0, psumValidOut[0], 0);
    checkVal("lat_p1_valid", 1, psumValidOut[1], 1);
    checkVal("lat_p1_sum", 1, psumOut[1], 34);
    checkVal("x_out_invalid_beat", 0, xOut[0], 8'sh5A);
    setIdle(); applyStimulus(); checkOutput();
    checkVal("lat_p1_passthru", 1, psumOut[1], 100);

    $display("[TB] local accumulate and drain");
    mode = 1;
    stepIdle(2);
    setIdle(); wLoad = 1; wIn = 4; applyStimulus(); checkOutput();
    setIdle(); wSwap = 1; applyStimulus(); checkOutput();
    for (int i = 1; i <= 3; i++) begin
      setIdle(); xValidIn = 1; xIn = DATA_W'(i); applyStimulus(); checkOutput();
      checkVal("la_no_valid_out", 0, psumValidOut[0], 0);
    end
    setIdle(); xValidIn = 1; xIn = 7; accDrain = 1; applyStimulus(); checkOutput();
    checkVal("la_drain1", 0, psumOut[0], 24);
    checkVal("la_drain1_valid", 0, psumValidOut[0], 1);
    setIdle(); applyStimulus(); checkOutput();
    checkVal("la_drain1_pulse", 0, psumValidOut[0], 0);
    checkVal("la_hold", 0, psumOut[0], 24);
    setIdle(); accDrain = 1; applyStimulus(); checkOutput();
    checkVal("la_drain2", 0, psumOut[0], 28);

    $display("[TB] negative extremes");
    mode = 0;
    stepIdle(2);
    setIdle(); wLoad = 1; wIn = -128; applyStimulus(); checkOutput();
    setIdle(); wSwap = 1; applyStimulus(); checkOutput();
    setIdle(); xValidIn = 1; xIn = -128; applyStimulus(); checkOutput();
    checkVal("neg_extreme", 0, psumOut[0], 16384);
    checkVal("neg_extreme_ovf", 0, ovf[0], 0);
    stepIdle(1);

    $display("[TB] random sweep");
    for (int cyc = 0; cyc < 10000; cyc++) begin
      phasePos = cyc % 250;
      quiet = (phasePos < 3) || (phasePos >= 247);
      mode = 1'((cyc / 250) % 2);
      wLoad = ($urandom_range(0, 7) == 0);
      wIn = DATA_W'($urandom);
      wSwap = ($urandom_range(0, 7) == 0);
      xIn = DATA_W'($urandom);
      if ($urandom_range(0, 1) == 0) psumIn = PSUM_W'($urandom);
      else psumIn = PSUM_W'($urandom_range(0, 4000) - 2000);
      xValidIn = !quiet && ($urandom_range(0, 3) != 0);
      accDrain = !quiet && ($urandom_range(0, 9) == 0);
      applyStimulus();
      checkOutput();
    end

    $display("[TB] saturation and sticky overflow");
    rstN = 0; mode = 0;
    setIdle(); applyStimulus(); checkOutput();
    rstN = 1;
    setIdle(); wLoad = 1; wIn = 127; applyStimulus(); checkOutput();
    setIdle(); wSwap = 1; applyStimulus(); checkOutput();
    checkVal("sat_ovf_clear", 0, ovf[0], 0);
    setIdle(); xValidIn = 1; xIn = 127; psumIn = 524000; applyStimulus(); checkOutput();
    checkVal("sat_clamp", 0, psumOut[0], 524287);
    checkVal("sat_clamp_ovf", 0, ovf[0], 1);
    checkVal("sat_wrap", 2, psumOut[2], 524000 + 16129 - 1048576);
    checkVal("sat_wrap_ovf", 2, ovf[2], 1);
    stepIdle(1);
    checkVal("sat_clamp_pipe", 1, psumOut[1], 524287);
    stepIdle(3);
    for (int k = 0; k < 3; k++) checkVal("ovf_sticky", k, ovf[k], 1);
    rstN = 0;
    setIdle(); applyStimulus(); checkOutput();
    for (int k = 0; k < 3; k++) checkVal("ovf_reset", k, ovf[k], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
